// File: rtl/int_to_fp_scheduler_if.sv
// Handshake bundle for the shared int-to-double conversion scheduler.
// The master side is the requesters plus the result consumer; the slave side
// is the scheduler itself.
interface int_to_fp_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [64*NUM_REQ-1:0] req_int;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [63:0]           out_fp;
    logic [ID_W-1:0]       out_id;
    logic                  busy;
    logic [31:0]           conv_count;

    modport master (
        output req_valid, req_int, out_ready,
        input  req_ready, out_valid, out_fp, out_id, busy, conv_count
    );

    modport slave (
        input  req_valid, req_int, out_ready,
        output req_ready, out_valid, out_fp, out_id, busy, conv_count
    );
endinterface

// File: rtl/int_to_fp_scheduler.sv
// Round-robin scheduler sharing one int64 -> IEEE double converter among
// NUM_REQ requesters. Accepted requests pass through one register stage into
// the converter and are queued in a result FIFO with registered head outputs.
// Issue credit counts both the stage and the FIFO, so the FIFO never overflows.
module int_to_fp_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    int_to_fp_scheduler_if.slave        bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 64 + ID_W;

    // Signed 64-bit integer to double, round-to-nearest-even; 0 maps to +0.0.
    function automatic logic [63:0] int_to_fp(input logic [63:0] v);
        logic        sign;
        logic [63:0] mag;
        logic [63:0] norm;
        logic [5:0]  msb;
        logic [62:0] body;
        logic        round_up;
        sign = v[63];
        mag  = sign ? (64'd0 - v) : v;
        msb  = 6'd0;
        for (int i = 0; i < 64; i++) begin
            msb = mag[i] ? 6'(i) : msb;
        end
        norm     = mag << (6'd63 - msb);
        round_up = norm[10] & ((|norm[9:0]) | norm[11]);
        body     = {11'd1023 + {5'd0, msb}, norm[62:11]};
        // A mantissa carry-out correctly bumps the exponent.
        body     = body + {62'd0, round_up};
        if (mag == 64'd0) begin
            int_to_fp = 64'd0;
        end else begin
            int_to_fp = {sign, body};
        end
    endfunction

    logic                  stage_valid_q, stage_valid_d;
    logic [63:0]           stage_int_q, stage_int_d;
    logic [ID_W-1:0]       stage_id_q, stage_id_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [31:0]           conv_count_q, conv_count_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]      head_q, head_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;

    logic                  can_issue_s;
    logic                  found_s;
    logic [ID_W-1:0]       win_s;
    logic [63:0]           win_int_s;
    logic [NUM_REQ-1:0]    grant_s;
    int                    best_off_s;
    logic                  push_s, pop_s;
    logic [ENT_W-1:0]      push_data_s;
    logic [PTR_W-1:0]      rd_next_s;

    // Credit check from registered occupancy only, then round-robin winner search.
    always_comb begin
        can_issue_s = (count_q + CNT_W'(stage_valid_q)) < CNT_W'(FIFO_DEPTH);
        best_off_s  = NUM_REQ;
        win_s       = '0;
        win_int_s   = 64'd0;
        grant_s     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] &&
                (((i - int'(rr_ptr_q) + NUM_REQ) % NUM_REQ) < best_off_s)) begin
                best_off_s = (i - int'(rr_ptr_q) + NUM_REQ) % NUM_REQ;
                win_s      = ID_W'(i);
            end else begin
                best_off_s = best_off_s;
            end
        end
        found_s = can_issue_s && (best_off_s < NUM_REQ);
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_s[i] = found_s && (win_s == ID_W'(i));
            if (win_s == ID_W'(i)) begin
                win_int_s = bus.req_int[64*i +: 64];
            end else begin
                win_int_s = win_int_s;
            end
        end
    end

    // Ready is forced low while reset is asserted so nothing looks accepted.
    assign bus.req_ready = grant_s & {NUM_REQ{rst_n}};

    // Next-state for stage, arbiter pointer, counter and result FIFO.
    always_comb begin
        push_s        = stage_valid_q;
        pop_s         = out_valid_q && bus.out_ready;
        push_data_s   = {int_to_fp(stage_int_q), stage_id_q};
        rd_next_s     = rd_ptr_q + PTR_W'(1);
        stage_valid_d = found_s;
        stage_int_d   = found_s ? win_int_s : stage_int_q;
        stage_id_d    = found_s ? win_s : stage_id_q;
        rr_ptr_d      = rr_ptr_q;
        conv_count_d  = conv_count_q;
        if (found_s) begin
            rr_ptr_d = (int'(win_s) == NUM_REQ - 1) ? '0 : win_s + ID_W'(1);
            conv_count_d = (conv_count_q == 32'hFFFF_FFFF) ? conv_count_q
                                                           : conv_count_q + 32'd1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_next_s : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Head register tracks what will sit at the FIFO head after this edge.
        if (push_s && (count_q == CNT_W'(0))) begin
            head_d = push_data_s;
        end else if (pop_s && (count_q > CNT_W'(1))) begin
            head_d = mem_q[rd_next_s];
        end else if (pop_s && push_s) begin
            head_d = push_data_s;
        end else begin
            head_d = head_q;
        end
        out_valid_d = (count_d != CNT_W'(0));
        busy_d      = stage_valid_d || (count_d != CNT_W'(0));
    end

    // State registers; reset discards every in-flight and queued result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_q <= 1'b0;
            stage_int_q   <= 64'd0;
            stage_id_q    <= '0;
            rr_ptr_q      <= '0;
            conv_count_q  <= 32'd0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            head_q        <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_int_q   <= stage_int_d;
            stage_id_q    <= stage_id_d;
            rr_ptr_q      <= rr_ptr_d;
            conv_count_q  <= conv_count_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            head_q        <= head_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= push_data_s;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_fp     = head_q[ENT_W-1:ID_W];
    assign bus.out_id     = head_q[ID_W-1:0];
    assign bus.busy       = busy_q;
    assign bus.conv_count = conv_count_q;
endmodule

// File: tb/tb_int_to_fp_scheduler.sv
// Randomized and directed bench for int_to_fp_scheduler. A queue-based model
// of accepted-but-not-consumed results predicts grants, output timing, data,
// busy and the acceptance counter; conversion uses the simulator's real type.
module tb_int_to_fp_scheduler;
    localparam int NREQ  = 4;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;

    logic clk;
    logic rst_n;

    int_to_fp_scheduler_if #(.NUM_REQ(NREQ), .ID_W(IDW)) bus ();

    int_to_fp_scheduler #(.NUM_REQ(NREQ), .FIFO_DEPTH(DEPTH), .ID_W(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] fp;
        int          id;
        int          acc;
    } ent_t;

    ent_t        q[$];
    int          rr;
    int          n_conv;
    int          cyc;
    int          n_tests;
    int          n_fail;
    logic [3:0]  st_valid;
    logic [63:0] st_int [NREQ];
    logic        st_ready;
    logic [3:0]  last_rdy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_fp(input logic [63:0] v);
        longint s;
        real    r;
        s = longint'(v);
        r = real'(s);
        return $realtobits(r);
    endfunction

    function automatic int ref_winner();
        if (q.size() >= DEPTH) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (st_valid[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive();
        bus.req_valid = st_valid;
        bus.req_int   = {st_int[3], st_int[2], st_int[1], st_int[0]};
        bus.out_ready = st_ready;
    endtask

    task automatic model_reset();
        q.delete();
        rr     = 0;
        n_conv = 0;
    endtask

    // One clock cycle: apply stimulus, check against model, advance model.
    task automatic step();
        int         w;
        logic [3:0] exp_rdy;
        logic       exp_v;
        @(negedge clk);
        drive();
        #1;
        w       = ref_winner();
        exp_rdy = (w >= 0) ? 4'(1 << w) : 4'd0;
        last_rdy = bus.req_ready;
        check_eq("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        exp_v = (q.size() > 0) && (q[0].acc < cyc);
        check_eq("out_valid", 64'(bus.out_valid), 64'(exp_v));
        if (exp_v) begin
            check_eq("out_fp", bus.out_fp, q[0].fp);
            check_eq("out_id", 64'(bus.out_id), 64'(q[0].id));
        end
        check_eq("busy", 64'(bus.busy), 64'(q.size() != 0));
        check_eq("conv_count", 64'(bus.conv_count), 64'(n_conv));
        if (exp_v && st_ready) void'(q.pop_front());
        if (w >= 0) begin
            q.push_back('{fp: ref_fp(st_int[w]), id: w, acc: cyc + 1});
            rr = (w + 1) % NREQ;
            if (n_conv != 32'hFFFF_FFFF) n_conv++;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle_steps(input int n, input logic rdy);
        st_valid = 4'd0;
        st_ready = rdy;
        for (int i = 0; i < n; i++) step();
    endtask

    // Single request on an idle block; result must appear one cycle after accept.
    task automatic send_one(input int r, input logic [63:0] v, input logic [63:0] exp_fp);
        st_valid    = 4'(1 << r);
        st_int[r]   = v;
        st_ready    = 1'b0;
        step();
        st_valid = 4'd0;
        step();
        #1;
        check_eq("dir_valid", 64'(bus.out_valid), 64'd1);
        check_eq("dir_fp", bus.out_fp, exp_fp);
        check_eq("dir_id", 64'(bus.out_id), 64'(r));
        idle_steps(1, 1'b1);
    endtask

    function automatic logic [63:0] rand_int();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0:       v = v;
            1:       v = v >> $urandom_range(0, 63);
            2:       v = 64'd0 - (v >> $urandom_range(0, 63));
            3:       v = (64'd1 << $urandom_range(53, 62)) | (v & 64'h3FF);
            default: v = (v[0]) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] c0;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        model_reset();
        rst_n    = 1'b0;
        st_valid = 4'd0;
        st_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) st_int[i] = 64'd0;
        drive();
        #1;
        check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_fp", bus.out_fp, 64'd0);
        check_eq("rst_id", 64'(bus.out_id), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_count", 64'(bus.conv_count), 64'd0);
        #21;
        rst_n = 1'b1;

        // Directed conversions including sign, extreme and rounding cases.
        send_one(0, 64'h0000_0000_0000_0001, 64'h3FF0_0000_0000_0000);
        check_eq("dir_count1", 64'(bus.conv_count), 64'd1);
        send_one(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hBFF0_0000_0000_0000);
        send_one(2, 64'h8000_0000_0000_0000, 64'hC3E0_0000_0000_0000);
        send_one(2, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000);
        send_one(1, 64'h0020_0000_0000_0001, 64'h4340_0000_0000_0000);
        send_one(3, 64'h0020_0000_0000_0003, 64'h4340_0000_0000_0002);

        // Fill stage plus three FIFO entries, then reset asynchronously.
        for (int i = 0; i < NREQ; i++) st_int[i] = 64'(i + 100);
        st_valid = 4'hF;
        st_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("arst_busy", 64'(bus.busy), 64'd0);
        check_eq("arst_ready", 64'(bus.req_ready), 64'd0);
        check_eq("arst_count", 64'(bus.conv_count), 64'd0);
        model_reset();
        @(negedge clk);
        st_valid = 4'd0;
        drive();
        #3;
        rst_n = 1'b1;
        idle_steps(3, 1'b1);

        // Fairness: every requester asking, grants rotate 0,1,2,3,...
        st_valid = 4'hF;
        st_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check_eq("fair_grant", 64'(last_rdy), 64'(1 << (k % NREQ)));
        end
        idle_steps(4, 1'b1);

        // Backpressure: exactly DEPTH transfers, then resume on consumption.
        c0       = bus.conv_count;
        st_valid = 4'hF;
        st_ready = 1'b0;
        for (int k = 0; k < 8; k++) step();
        check_eq("bp_xfers", 64'(bus.conv_count - c0), 64'(DEPTH));
        check_eq("bp_ready", 64'(last_rdy), 64'd0);
        st_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        idle_steps(6, 1'b1);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            st_valid = 4'($urandom);
            for (int i = 0; i < NREQ; i++) st_int[i] = rand_int();
            st_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle_steps(10, 1'b1);
        check_eq("drain_empty", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/int_to_fp_scheduler.md
Name: int_to_fp_scheduler

Overview:
Shares one combinational int_to_fp converter among NUM_REQ requesters. Each requester offers a 64-bit signed integer over a valid/ready channel. Requests are granted round-robin, pushed through a registered conversion stage, and queued in a result FIFO. Results leave on a single valid/ready output channel tagged with the requester index. The block sits between the integer-issue logic and the FP result writeback.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
FIFO_DEPTH, 4, result FIFO entries (power of two, >=2)
ID_W, 2, width of requester tag; must be >= clog2(NUM_REQ)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_int  input  64*NUM_REQ  per-requester signed integer; requester i uses bits [64*i+63:64*i]
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
out_valid  output  1  result available at FIFO head
out_ready  input  1  consumer accepts result
out_fp  output  64  IEEE-754 double result
out_id  output  ID_W  requester index of the result
busy  output  1  high while any stage or FIFO entry holds data
conv_count  output  32  accepted-request counter, saturates at 0xFFFFFFFF

Behaviour:
- Reset (async assert, sync-released by clk): stage_valid=0, FIFO empty, rr_ptr=0, conv_count=0. All outputs read 0: req_ready, out_valid, out_fp, out_id, busy.
- Reset mid-operation discards in-flight and queued results. No partial output follows release.
- Credit: can_issue = (fifo_count + stage_valid) < FIFO_DEPTH.
  - Uses registered values only. A same-cycle FIFO pop does not create credit until the next cycle.
- Arbitration (combinational):
  - Search order rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - The first index with req_valid high wins, if can_issue.
  - req_ready[winner]=1, all other bits 0. With no winner or no credit, req_ready is all zero.
- Transfer on requester i: req_valid[i] && req_ready[i] at a rising edge.
  - Stage register captures {req_int[i], i}; stage_valid=1.
  - rr_ptr <= (i+1) mod NUM_REQ; rr_ptr is unchanged when there is no transfer.
  - conv_count increments (saturating).
- Converter: one int_to_fp instance, driven combinationally from the stage register. Required rounding is round-to-nearest-even; 0 gives +0.0.
- Next edge with stage_valid=1: {fp_out, id} is written into the FIFO. stage_valid is cleared unless a new transfer happens on the same edge, in which case it reloads.
  - Throughput: one conversion per cycle.
- FIFO:
  - out_valid = (fifo_count != 0); out_fp/out_id show the head entry and are registered, with no fall-through.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop is legal at any count, including full, and leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow cannot occur by construction of the credit rule. Verification asserts fifo_count <= FIFO_DEPTH.
- Latency: transfer at edge E0 → stage loaded. Write at E1 → out_valid high after E1 with the correct data. Minimum 1 cycle from accept to visible result.
- Ordering: results leave in acceptance order, which makes out_id sequences deterministic.
- Holding req_valid low after a transfer is the requester's duty. A request held high is re-arbitrated and may be accepted again.
- busy = stage_valid | (fifo_count != 0).
- Empty FIFO: out_fp/out_id hold their last value (0 after reset) and are don't-care while out_valid=0.

Test Plan:
- Single requester 0 sends 0x0000000000000001; out_ready=1 → out_valid one cycle after accept, out_fp=0x3FF0000000000000, out_id=0, conv_count=1.
- Requester 2 sends 0xFFFFFFFFFFFFFFFF, then 0x8000000000000000, then 0 → out_fp 0xBFF0000000000000, 0xC3E0000000000000, 0x0000000000000000, all out_id=2.
- Rounding: 0x0020000000000001 → 0x4340000000000000; 0x0020000000000003 → 0x4340000000000002.
- Fairness: all four req_valid held high for 8 cycles, out_ready=1 → one grant per cycle, out_id sequence 0,1,2,3,0,1,2,3.
- Backpressure: out_ready=0, all valid, FIFO_DEPTH=4 → exactly 4 transfers, then req_ready=0 permanently. Raising out_ready resumes one transfer per cycle, each starting the cycle after the pop that freed the credit; no result is lost or duplicated.
- Reset: assert rst_n=0 with stage loaded and FIFO holding 3 entries → out_valid, busy, req_ready, conv_count all 0 immediately (asynchronously). After release with no new requests, out_valid stays 0.
